sd_data_phy_ctrl: RTL and testbench

Parametrised DATA-line physical-layer controller for the SD host. It sits between the DATA transaction layer and the FIFO, parallel-to-serial (PS) and serial-to-parallel (SP) wrappers and the DAT pad. It sequences single- and multi-block writes and reads, moves one DATA_W word per block between the FIFO and the serializers, and enforces a per-block read timeout. It holds `complete` until the transaction layer acknowledges.

---
 rtl/sd_data_phy_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_sd_data_phy_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_data_phy_ctrl.sv
// sd_data_phy_ctrl: DATA-line PHY sequencer between transaction layer, FIFO, PS/SP wrappers and DAT pad.
// Define SD_DATA_PHY_TIMEOUT_EN to build the per-block read timeout counter and timeout_Phy_DATA flag.
module sd_data_phy_ctrl #(
    parameter int DATA_W    = 32,
    parameter int BLK_CNT_W = 4,
    parameter int TO_W      = 16
) (
    input  logic                 SD_CLK,
    input  logic                 RESET_L,
    input  logic                 strobe_IN_DATA_Phy,
    input  logic                 ack_IN_DATA_Phy,
    input  logic [TO_W-1:0]      timeout_Reg_DATA_Phy,
    input  logic [BLK_CNT_W-1:0] blocks_DATA_Phy,
    input  logic                 writeRead_DATA_Phy,
    input  logic                 multiple_DATA_Phy,
    input  logic                 idle_in_DATA_Phy,
    input  logic                 transmission_complete_PS_Phy,
    input  logic                 reception_complete_SP_Phy,
    input  logic [DATA_W-1:0]    data_read_SP_Phy,
    input  logic [DATA_W-1:0]    dataFromFIFO_FIFO_Phy,
    output logic                 complete_Phy_DATA,
    output logic                 timeout_Phy_DATA,
    output logic                 readFIFO_enable_Phy_FIFO,
    output logic                 writeFIFO_enable_Phy_FIFO,
    output logic [DATA_W-1:0]    dataReadToFIFO_Phy_FIFO,
    output logic [DATA_W-1:0]    dataParallel_Phy_PS,
    output logic                 enable_pts_Wrapper_Phy_PS,
    output logic                 enable_stp_Wrapper_Phy_SP,
    output logic                 pad_state_Phy_PAD,
    output logic                 pad_enable_Phy_PAD
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIFO_READ,
        ST_LOAD_WRITE,
        ST_SEND,
        ST_READ,
        ST_WRITE_FIFO,
        ST_WAIT_ACK
    } state_e;

    localparam logic [BLK_CNT_W-1:0] BLK_ONE = BLK_CNT_W'(1);

    state_e               state_q, state_d;
    logic [BLK_CNT_W-1:0] remaining_q, remaining_d;
    logic [DATA_W-1:0]    data_ps_q, data_ps_d;
    logic [DATA_W-1:0]    data_fifo_q, data_fifo_d;
    logic                 timeout_expired;

`ifdef SD_DATA_PHY_TIMEOUT_EN
    logic [TO_W-1:0] to_limit_q, to_limit_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [TO_W-1:0] to_cnt_inc;
    logic            timeout_flag_q, timeout_flag_d;

    // The count for the current READ cycle is compared, so expiry lands exactly `limit` cycles after READ entry.
    assign to_cnt_inc      = to_cnt_q + 1'b1;
    assign timeout_expired = (to_limit_q != '0) && (to_cnt_inc == to_limit_q);

    always_comb begin
        to_limit_d     = to_limit_q;
        to_cnt_d       = to_cnt_q;
        timeout_flag_d = timeout_flag_q;
        if (idle_in_DATA_Phy) begin
            to_cnt_d       = '0;
            timeout_flag_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (strobe_IN_DATA_Phy) begin
                    to_limit_d = timeout_Reg_DATA_Phy;
                    to_cnt_d   = '0;
                end
                ST_READ: begin
                    to_cnt_d = to_cnt_inc;
                    if (!reception_complete_SP_Phy && timeout_expired) timeout_flag_d = 1'b1;
                end
                ST_WRITE_FIFO: to_cnt_d = '0;
                ST_WAIT_ACK:   if (ack_IN_DATA_Phy) timeout_flag_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge SD_CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            to_limit_q     <= '0;
            to_cnt_q       <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            to_limit_q     <= to_limit_d;
            to_cnt_q       <= to_cnt_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign timeout_Phy_DATA = timeout_flag_q;
`else
    logic unused_timeout_reg;
    assign unused_timeout_reg = ^timeout_Reg_DATA_Phy;
    assign timeout_expired    = 1'b0;
    assign timeout_Phy_DATA   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        data_ps_d   = data_ps_q;
        data_fifo_d = data_fifo_q;
        if (idle_in_DATA_Phy) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
            data_ps_d   = '0;
            data_fifo_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (strobe_IN_DATA_Phy) begin
                    remaining_d = (multiple_DATA_Phy && blocks_DATA_Phy != '0) ? blocks_DATA_Phy : BLK_ONE;
                    state_d     = writeRead_DATA_Phy ? ST_FIFO_READ : ST_READ;
                end
                ST_FIFO_READ: state_d = ST_LOAD_WRITE;
                ST_LOAD_WRITE: begin
                    data_ps_d = dataFromFIFO_FIFO_Phy;
                    state_d   = ST_SEND;
                end
                ST_SEND: if (transmission_complete_PS_Phy) begin
                    remaining_d = remaining_q - 1'b1;
                    state_d     = (remaining_q > BLK_ONE) ? ST_FIFO_READ : ST_WAIT_ACK;
                end
                ST_READ: begin
                    if (reception_complete_SP_Phy) begin
                        data_fifo_d = data_read_SP_Phy;
                        state_d     = ST_WRITE_FIFO;
                    end else if (timeout_expired) begin
                        state_d = ST_WAIT_ACK;
                    end
                end
                ST_WRITE_FIFO: begin
                    remaining_d = remaining_q - 1'b1;
                    state_d     = (remaining_q > BLK_ONE) ? ST_READ : ST_WAIT_ACK;
                end
                ST_WAIT_ACK: if (ack_IN_DATA_Phy) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge SD_CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            data_ps_q   <= '0;
            data_fifo_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            data_ps_q   <= data_ps_d;
            data_fifo_q <= data_fifo_d;
        end
    end

    // Control outputs decode the registered state only, so reset clears them without waiting for an edge.
    always_comb begin
        complete_Phy_DATA         = 1'b0;
        readFIFO_enable_Phy_FIFO  = 1'b0;
        writeFIFO_enable_Phy_FIFO = 1'b0;
        enable_pts_Wrapper_Phy_PS = 1'b0;
        enable_stp_Wrapper_Phy_SP = 1'b0;
        pad_state_Phy_PAD         = 1'b0;
        pad_enable_Phy_PAD        = 1'b0;
        case (state_q)
            ST_FIFO_READ:  readFIFO_enable_Phy_FIFO = 1'b1;
            ST_SEND: begin
                enable_pts_Wrapper_Phy_PS = 1'b1;
                pad_state_Phy_PAD         = 1'b1;
                pad_enable_Phy_PAD        = 1'b1;
            end
            ST_READ: begin
                enable_stp_Wrapper_Phy_SP = 1'b1;
                pad_enable_Phy_PAD        = 1'b1;
            end
            ST_WRITE_FIFO: writeFIFO_enable_Phy_FIFO = 1'b1;
            ST_WAIT_ACK:   complete_Phy_DATA = 1'b1;
            default: ;
        endcase
    end

    assign dataParallel_Phy_PS     = data_ps_q;
    assign dataReadToFIFO_Phy_FIFO = data_fifo_q;

endmodule

// File: tb/tb_sd_data_phy_ctrl.sv
// Directed bench for sd_data_phy_ctrl; expectations follow the macro setting shared with the RTL build.
module tb_sd_data_phy_ctrl;
    localparam int DATA_W    = 32;
    localparam int BLK_CNT_W = 4;
    localparam int TO_W      = 16;

    logic                 SD_CLK = 1'b0;
    logic                 RESET_L = 1'b0;
    logic                 strobe = 1'b0, ack = 1'b0, write_read = 1'b0, multiple = 1'b0, idle_in = 1'b0;
    logic                 tx_done = 1'b0, rx_done = 1'b0;
    logic [TO_W-1:0]      timeout_reg = '0;
    logic [BLK_CNT_W-1:0] blocks = '0;
    logic [DATA_W-1:0]    sp_data = '0, fifo_data = '0;

    logic              complete, timeout, rd_en, wr_en, pts_en, stp_en, pad_state, pad_en;
    logic [DATA_W-1:0] to_fifo, to_ps;
    logic [2*DATA_W+7:0] all_out;

    int checks = 0;
    int errors = 0;
    int rd_pops = 0;
    int wr_pushes = 0;

    sd_data_phy_ctrl #(.DATA_W(DATA_W), .BLK_CNT_W(BLK_CNT_W), .TO_W(TO_W)) dut (
        .SD_CLK                       (SD_CLK),
        .RESET_L                      (RESET_L),
        .strobe_IN_DATA_Phy           (strobe),
        .ack_IN_DATA_Phy              (ack),
        .timeout_Reg_DATA_Phy         (timeout_reg),
        .blocks_DATA_Phy              (blocks),
        .writeRead_DATA_Phy           (write_read),
        .multiple_DATA_Phy            (multiple),
        .idle_in_DATA_Phy             (idle_in),
        .transmission_complete_PS_Phy (tx_done),
        .reception_complete_SP_Phy    (rx_done),
        .data_read_SP_Phy             (sp_data),
        .dataFromFIFO_FIFO_Phy        (fifo_data),
        .complete_Phy_DATA            (complete),
        .timeout_Phy_DATA             (timeout),
        .readFIFO_enable_Phy_FIFO     (rd_en),
        .writeFIFO_enable_Phy_FIFO    (wr_en),
        .dataReadToFIFO_Phy_FIFO      (to_fifo),
        .dataParallel_Phy_PS          (to_ps),
        .enable_pts_Wrapper_Phy_PS    (pts_en),
        .enable_stp_Wrapper_Phy_SP    (stp_en),
        .pad_state_Phy_PAD            (pad_state),
        .pad_enable_Phy_PAD           (pad_en)
    );

    assign all_out = {complete, timeout, rd_en, wr_en, pts_en, stp_en, pad_state, pad_en, to_fifo, to_ps};

    always #5 SD_CLK = ~SD_CLK;

    // The bench plays the FIFO: each full-cycle enable is one pop or push.
    always @(negedge SD_CLK) begin
        if (rd_en === 1'b1) rd_pops <= rd_pops + 1;
        if (wr_en === 1'b1) wr_pushes <= wr_pushes + 1;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge SD_CLK);
        #1;
    endtask

    task automatic test_reset;
        step(2);
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        RESET_L = 1'b1;
        step(2);
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL post_reset_idle: got %h expected 0", all_out); end
    endtask

    task automatic test_single_write;
        int pops0;
        pops0 = rd_pops;
        write_read = 1'b1; multiple = 1'b0; blocks = 4'd5; fifo_data = 32'hCAFECAFE; strobe = 1'b1;
        step();
        strobe = 1'b0;
        checks++;
        if (rd_en !== 1'b1 || pad_en !== 1'b0) begin errors++; $display("FAIL sw_fifo_read: rd_en=%b pad_en=%b expected 1,0", rd_en, pad_en); end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (rd_en !== 1'b0 || pts_en !== 1'b0) begin errors++; $display("FAIL sw_load: rd_en=%b pts=%b expected 0,0", rd_en, pts_en); end
        step(3);
        checks++;
        if ({pts_en, pad_state, pad_en, complete} !== 4'b1110 || to_ps !== 32'hCAFECAFE) begin
            errors++; $display("FAIL sw_send: ctl=%b data=%h expected 1110 CAFECAFE", {pts_en, pad_state, pad_en, complete}, to_ps);
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step(2);
        checks++;
        if ({complete, pts_en, pad_en, rd_en} !== 4'b1000) begin errors++; $display("FAIL sw_complete: ctl=%b expected 1000", {complete, pts_en, pad_en, rd_en}); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (complete !== 1'b0 || rd_pops - pops0 !== 1) begin errors++; $display("FAIL sw_ack: complete=%b pops=%0d expected 0,1", complete, rd_pops - pops0); end
    endtask

    task automatic test_multi_read;
        int push0;
        push0 = wr_pushes;
        write_read = 1'b0; multiple = 1'b1; blocks = 4'd3; timeout_reg = '0; strobe = 1'b1;
        step();
        strobe = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if ({stp_en, pad_state, pad_en} !== 3'b101) begin errors++; $display("FAIL mr_read_%0d: ctl=%b expected 101", i, {stp_en, pad_state, pad_en}); end
            step(2);
            sp_data = i; rx_done = 1'b1;
            step();
            rx_done = 1'b0;
            checks++;
            if (wr_en !== 1'b1 || to_fifo !== i) begin errors++; $display("FAIL mr_push_%0d: wr_en=%b data=%h expected 1 %h", i, wr_en, to_fifo, i); end
            step();
        end
        checks++;
        if (complete !== 1'b1 || timeout !== 1'b0 || wr_pushes - push0 !== 3) begin
            errors++; $display("FAIL mr_complete: complete=%b timeout=%b pushes=%0d expected 1,0,3", complete, timeout, wr_pushes - push0);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic test_timeout;
        int push0;
        push0 = wr_pushes;
        write_read = 1'b0; multiple = 1'b0; timeout_reg = 16'd100; strobe = 1'b1;
        step();
        strobe = 1'b0;
        step(99);
        checks++;
        if (stp_en !== 1'b1 || complete !== 1'b0) begin errors++; $display("FAIL to_before: stp=%b complete=%b expected 1,0", stp_en, complete); end
        step();
`ifdef SD_DATA_PHY_TIMEOUT_EN
        checks++;
        if ({complete, timeout, stp_en} !== 3'b110 || wr_pushes != push0) begin
            errors++; $display("FAIL to_expire: ctl=%b pushes=%0d expected 110,0", {complete, timeout, stp_en}, wr_pushes - push0);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (complete !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL to_ack: complete=%b timeout=%b expected 0,0", complete, timeout); end
`else
        step(50);
        checks++;
        if ({complete, timeout, stp_en} !== 3'b001 || wr_pushes != push0) begin
            errors++; $display("FAIL to_disabled: ctl=%b pushes=%0d expected 001,0", {complete, timeout, stp_en}, wr_pushes - push0);
        end
        idle_in = 1'b1;
        step();
        idle_in = 1'b0;
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL to_abort: got %h expected 0", all_out); end
`endif
        timeout_reg = '0;
    endtask

    task automatic test_abort;
        int pops0;
        logic [DATA_W-1:0] words [3];
        words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
        pops0 = rd_pops;
        write_read = 1'b1; multiple = 1'b1; blocks = 4'd15; fifo_data = words[0]; strobe = 1'b1;
        step();
        strobe = 1'b0;
        for (int b = 0; b < 2; b++) begin
            step(2);
            checks++;
            if (pts_en !== 1'b1 || to_ps !== words[b]) begin errors++; $display("FAIL ab_send_%0d: pts=%b data=%h expected 1 %h", b, pts_en, to_ps, words[b]); end
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            fifo_data = words[b+1];
        end
        checks++;
        if (rd_en !== 1'b1) begin errors++; $display("FAIL ab_third_pop: rd_en=%b expected 1", rd_en); end
        idle_in = 1'b1;
        step();
        idle_in = 1'b0;
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL ab_idle: got %h expected 0", all_out); end
        step(3);
        checks++;
        if (all_out !== '0 || rd_pops - pops0 !== 3) begin errors++; $display("FAIL ab_quiet: out=%h pops=%0d expected 0,3", all_out, rd_pops - pops0); end
    endtask

    task automatic test_blocks_zero;
        int pops0;
        pops0 = rd_pops;
        write_read = 1'b1; multiple = 1'b1; blocks = 4'd0; fifo_data = 32'h0BADF00D; strobe = 1'b1;
        step();
        strobe = 1'b0;
        step(2);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (complete !== 1'b1 || rd_en !== 1'b0 || rd_pops - pops0 !== 1) begin
            errors++; $display("FAIL bz_one_block: complete=%b rd_en=%b pops=%0d expected 1,0,1", complete, rd_en, rd_pops - pops0);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic test_coincide;
        write_read = 1'b0; multiple = 1'b0; timeout_reg = 16'd5; strobe = 1'b1;
        step();
        strobe = 1'b0;
        step(4);
        sp_data = 32'hA5A5A5A5; rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || to_fifo !== 32'hA5A5A5A5 || timeout !== 1'b0) begin
            errors++; $display("FAIL co_push: wr_en=%b data=%h timeout=%b expected 1 A5A5A5A5 0", wr_en, to_fifo, timeout);
        end
        step();
        checks++;
        if (complete !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL co_complete: complete=%b timeout=%b expected 1,0", complete, timeout); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        timeout_reg = '0;
    endtask

    task automatic test_back_to_back;
        write_read = 1'b0; multiple = 1'b0; strobe = 1'b1;
        step();
        sp_data = 32'hDEADBEEF; rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (complete !== 1'b0 || stp_en !== 1'b0) begin errors++; $display("FAIL bb_idle: complete=%b stp=%b expected 0,0", complete, stp_en); end
        step();
        checks++;
        if (stp_en !== 1'b1) begin errors++; $display("FAIL bb_restart: stp=%b expected 1", stp_en); end
        strobe = 1'b0; idle_in = 1'b1;
        step();
        idle_in = 1'b0;
    endtask

    task automatic test_reset_mid_send;
        write_read = 1'b1; multiple = 1'b1; blocks = 4'd4; fifo_data = 32'h12345678; strobe = 1'b1;
        step();
        strobe = 1'b0;
        step(2);
        RESET_L = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL rst_immediate: got %h expected 0", all_out); end
        #29;
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL rst_held: got %h expected 0", all_out); end
        RESET_L = 1'b1;
        fifo_data = 32'h87654321; multiple = 1'b0; strobe = 1'b1;
        step();
        strobe = 1'b0;
        checks++;
        if (rd_en !== 1'b1) begin errors++; $display("FAIL rst_fresh_pop: rd_en=%b expected 1", rd_en); end
        step(2);
        checks++;
        if (to_ps !== 32'h87654321) begin errors++; $display("FAIL rst_fresh_data: got %h expected 87654321", to_ps); end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (complete !== 1'b1) begin errors++; $display("FAIL rst_fresh_complete: got %b expected 1", complete); end
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_multi_read();
        test_timeout();
        test_abort();
        test_blocks_zero();
        test_coincide();
        test_back_to_back();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
